// File: rtl/clock_set_editor.sv
// clock_set_editor
//   Button-driven editor for the decade clock/calendar counter. Debounces the
//   three active-low buttons, walks the fields of the selected mode, edits a
//   BCD shadow copy and emits a one-cycle load strobe on commit.
//
// Ports
//   clk, rst                      system clock, async active-high reset
//   butt_increase/decrease/change raw buttons, pressed = 0
//   sw_mode                       0 = time edit, 1 = date edit
//   cur_time  [23:0]              {h1,h0,m1,m0,s1,s0} BCD from the counter
//   cur_date  [31:0]              {d1,d0,mo1,mo0,y3,y2,y1,y0} BCD
//   set_time / set_date           shadow values being edited
//   ld_time / ld_date             one-cycle commit strobes
//   edit_active                   high in any FIELD state
//   edit_field [1:0]              0 = none, 1..3 = field under edit
//
// Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN
//   When defined, holding inc/dec in a FIELD state generates repeat events
//   after REPEAT_DELAY cycles and then every REPEAT_CYCLES.
module clock_set_editor #(
    parameter int DEB_CYCLES     = 500_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_CYCLES  = 5_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        butt_increase,
    input  logic        butt_decrease,
    input  logic        butt_change,
    input  logic        sw_mode,
    input  logic [23:0] cur_time,
    input  logic [31:0] cur_date,
    output logic [23:0] set_time,
    output logic [31:0] set_date,
    output logic        ld_time,
    output logic        ld_date,
    output logic        edit_active,
    output logic [1:0]  edit_field
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_FIELD1, S_FIELD2, S_FIELD3, S_COMMIT} state_t;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    // Two-digit BCD step within [lo,hi], wrapping both ways. Anything not a
    // valid in-range BCD value snaps to lo on inc and hi on dec.
    function automatic logic [7:0] bcd2_step(input logic [7:0] v, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic up);
        logic       ok;
        logic [7:0] r;
        ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
        if (!ok)                r = up ? lo : hi;
        else if (up && v == hi) r = lo;
        else if (!up && v == lo) r = hi;
        else if (up)            r = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
        else                    r = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Four-digit BCD year step, 0000..9999 with ripple carry/borrow.
    function automatic logic [15:0] bcd4_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        carry;
        logic        bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin r[4*i +: 4] = v[4*i +: 4] + 4'd1; carry = 1'b0; end
                end else begin
                    if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin r[4*i +: 4] = v[4*i +: 4] - 4'd1; carry = 1'b0; end
                end
            end
        end
        if (bad) r = up ? 16'h0000 : 16'h9999;
        return r;
    endfunction

    // Two BCD digits {t,o} divisible by 4: 10t+o = 2t+o (mod 4).
    function automatic logic bcd_div4(input logic [3:0] t, input logic [3:0] o);
        return t[0] ? (o == 4'd2 || o == 4'd6) : (o == 4'd0 || o == 4'd4 || o == 4'd8);
    endfunction

    function automatic logic [7:0] day_max(input logic [7:0] mon, input logic [15:0] yr);
        logic leap;
        logic [7:0] r;
        leap = bcd_div4(yr[7:4], yr[3:0]) &&
               ((yr[7:0] != 8'h00) || bcd_div4(yr[15:12], yr[11:8]));
        case (mon)
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            8'h02:                      r = leap ? 8'h29 : 8'h28;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning: index 0 = inc, 1 = dec, 2 = change
    // ------------------------------------------------------------------
    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         deb_q, deb_d;
    logic [2:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]         press_ev;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]     = deb_q[i];
            deb_cnt_d[i] = '0;
            press_ev[i]  = 1'b0;
            // Count consecutive cycles at the new level; any bounce back clears.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[i]    = sync2_q[i];
                    press_ev[i] = ~sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            deb_q     <= 3'b111;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= {butt_change, butt_decrease, butt_increase};
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM / shadow registers
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic           edit_mode_q, edit_mode_d;
    logic [23:0]    set_time_q, set_time_d;
    logic [31:0]    set_date_q, set_date_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           in_field;
    logic           inc_ev, dec_ev;

    assign in_field = (state_q == S_FIELD1) || (state_q == S_FIELD2) || (state_q == S_FIELD3);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]         rpt_ev;

    // Hold counter per inc/dec: counts cycles held since the debounced press,
    // fires at REPEAT_DELAY, then reloads so it fires every REPEAT_CYCLES.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_cnt_d[i] = '0;
            rpt_ev[i]    = 1'b0;
            if (in_field && !deb_q[i]) begin
                if (rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                    rpt_ev[i]    = 1'b1;
                    rpt_cnt_d[i] = RW'(REPEAT_DELAY - REPEAT_CYCLES);
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rpt_cnt_q <= '0;
        else     rpt_cnt_q <= rpt_cnt_d;
    end

    assign inc_ev = press_ev[0] | rpt_ev[0];
    assign dec_ev = press_ev[1] | rpt_ev[1];
`else
    assign inc_ev = press_ev[0];
    assign dec_ev = press_ev[1];
`endif

    logic chg_ev, step_up, step_dn;
    assign chg_ev  = press_ev[2];
    // Change wins; simultaneous inc+dec cancel.
    assign step_up = !chg_ev && inc_ev && !dec_ev;
    assign step_dn = !chg_ev && dec_ev && !inc_ev;

    always_comb begin
        state_d     = state_q;
        edit_mode_d = edit_mode_q;
        set_time_d  = set_time_q;
        set_date_d  = set_date_q;
        timer_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (chg_ev) begin
                    set_time_d  = cur_time;
                    set_date_d  = cur_date;
                    edit_mode_d = sw_mode;
                    state_d     = S_FIELD1;
                end
            end
            S_FIELD1, S_FIELD2, S_FIELD3: begin
                timer_d = timer_q + TW'(1);
                if (sw_mode != edit_mode_q) begin
                    state_d = S_IDLE;
                end else if (chg_ev) begin
                    timer_d = '0;
                    case (state_q)
                        S_FIELD1: state_d = S_FIELD2;
                        S_FIELD2: state_d = S_FIELD3;
                        default: begin
                            state_d = S_COMMIT;
                            // Clamp the day now so set_date is final while ld_date is high.
                            if (edit_mode_q &&
                                set_date_q[31:24] > day_max(set_date_q[23:16], set_date_q[15:0]))
                                set_date_d[31:24] = day_max(set_date_q[23:16], set_date_q[15:0]);
                        end
                    endcase
                end else if (step_up || step_dn) begin
                    timer_d = '0;
                    if (!edit_mode_q) begin
                        case (state_q)
                            S_FIELD1: set_time_d[23:16] = bcd2_step(set_time_q[23:16], 8'h00, 8'h23, step_up);
                            S_FIELD2: set_time_d[15:8]  = bcd2_step(set_time_q[15:8],  8'h00, 8'h59, step_up);
                            // Seconds are reset-style: inc zeroes, dec goes to 59.
                            default:  set_time_d[7:0]   = step_up ? 8'h00 : 8'h59;
                        endcase
                    end else begin
                        case (state_q)
                            S_FIELD1: set_date_d[31:24] = bcd2_step(set_date_q[31:24], 8'h01,
                                          day_max(set_date_q[23:16], set_date_q[15:0]), step_up);
                            S_FIELD2: set_date_d[23:16] = bcd2_step(set_date_q[23:16], 8'h01, 8'h12, step_up);
                            default:  set_date_d[15:0]  = bcd4_step(set_date_q[15:0], step_up);
                        endcase
                    end
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;   // S_COMMIT lasts one cycle
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            edit_mode_q <= 1'b0;
            set_time_q  <= '0;
            set_date_q  <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            edit_mode_q <= edit_mode_d;
            set_time_q  <= set_time_d;
            set_date_q  <= set_date_d;
            timer_q     <= timer_d;
        end
    end

    assign set_time    = set_time_q;
    assign set_date    = set_date_q;
    assign ld_time     = (state_q == S_COMMIT) && !edit_mode_q;
    assign ld_date     = (state_q == S_COMMIT) &&  edit_mode_q;
    assign edit_active = in_field;
    assign edit_field  = (state_q == S_FIELD1) ? 2'd1 :
                         (state_q == S_FIELD2) ? 2'd2 :
                         (state_q == S_FIELD3) ? 2'd3 : 2'd0;

endmodule

// File: tb/tb_clock_set_editor.sv
// Directed bench for clock_set_editor with short debounce/timeout settings.
module tb_clock_set_editor;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        butt_increase, butt_decrease, butt_change, sw_mode;
    logic [23:0] cur_time, set_time;
    logic [31:0] cur_date, set_date;
    logic        ld_time, ld_date, edit_active;
    logic [1:0]  edit_field;

    int checks   = 0;
    int failures = 0;
    int ld_time_cnt = 0;
    int ld_date_cnt = 0;
    logic [23:0] last_time_ld = '0;
    logic [31:0] last_date_ld = '0;

    clock_set_editor #(
        .DEB_CYCLES(DEB),
        .TIMEOUT_CYCLES(200)
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        , .REPEAT_DELAY(20)
        , .REPEAT_CYCLES(5)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
        .sw_mode(sw_mode), .cur_time(cur_time), .cur_date(cur_date),
        .set_time(set_time), .set_date(set_date),
        .ld_time(ld_time), .ld_date(ld_date),
        .edit_active(edit_active), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts high cycles of each load strobe and the value it carried.
    always @(posedge clk) begin
        if (ld_time) begin ld_time_cnt++; last_time_ld = set_time; end
        if (ld_date) begin ld_date_cnt++; last_date_ld = set_date; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = inc, 1 = dec, 2 = change, 3 = inc+dec together
    task automatic press(input int which);
        case (which)
            0: butt_increase = 1'b0;
            1: butt_decrease = 1'b0;
            2: butt_change   = 1'b0;
            default: begin butt_increase = 1'b0; butt_decrease = 1'b0; end
        endcase
        tick(DEB + 4);
        butt_increase = 1'b1; butt_decrease = 1'b1; butt_change = 1'b1;
        tick(DEB + 4);
    endtask

    initial begin
        rst = 1'b1;
        butt_increase = 1'b1; butt_decrease = 1'b1; butt_change = 1'b1;
        sw_mode  = 1'b0;
        cur_time = 24'h235930;
        cur_date = 32'h15062022;
        tick(3);
        check("rst_set_time", 32'(set_time), 32'h0);
        check("rst_set_date", set_date, 32'h0);
        check("rst_ld", {30'd0, ld_time, ld_date}, 32'h0);
        check("rst_edit", {29'd0, edit_active, edit_field}, 32'h0);
        rst = 1'b0;
        tick(2);

        // Time roll-up 23:59:30 -> 00:00:30
        press(2);
        check("roll_enter_field", 32'(edit_field), 32'd1);
        check("roll_copy", 32'(set_time), 32'h235930);
        press(0);
        check("roll_hour_wrap", 32'(set_time), 32'h005930);
        press(2);
        check("roll_field2", 32'(edit_field), 32'd2);
        press(0);
        check("roll_min_wrap", 32'(set_time), 32'h000030);
        press(2);
        press(2);
        check("roll_ld_time_cnt", ld_time_cnt, 32'd1);
        check("roll_ld_date_cnt", ld_date_cnt, 32'd0);
        check("roll_ld_value", 32'(last_time_ld), 32'h000030);
        check("roll_idle", 32'(edit_active), 32'd0);
        check("roll_hold", 32'(set_time), 32'h000030);

        // Hour dec, minute dec wrap with bounce, seconds inc -> 00
        cur_time = 24'h090045;
        press(2);
        press(1);
        check("dec_hour", 32'(set_time), 32'h080045);
        press(2);
        for (int g = 0; g < 2; g++) begin
            butt_decrease = 1'b0; tick(2);
            butt_decrease = 1'b1; tick(10);
        end
        check("glitch_no_change", 32'(set_time), 32'h080045);
        butt_decrease = 1'b0;
        tick(5);
        check("clean_dec_not_yet", 32'(set_time), 32'h080045);
        tick(1);
        check("clean_dec_wrap59", 32'(set_time), 32'h085945);
        tick(DEB + 2);
        butt_decrease = 1'b1;
        tick(DEB + 4);
        press(2);
        press(0);
        check("sec_inc_zero", 32'(set_time), 32'h085900);
        press(2);
        check("sec_ld_value", 32'(last_time_ld), 32'h085900);
        check("sec_ld_time_cnt", ld_time_cnt, 32'd2);

        // Date leap clamp 31-01-2023 -> 29-02-2024
        sw_mode  = 1'b1;
        cur_date = 32'h31012023;
        press(2);
        press(2);
        press(0);
        check("leap_month", set_date, 32'h31022023);
        press(2);
        press(0);
        check("leap_year", set_date, 32'h31022024);
        press(2);
        check("leap_ld_value", last_date_ld, 32'h29022024);
        check("leap_ld_date_cnt", ld_date_cnt, 32'd1);
        check("leap_ld_time_cnt", ld_time_cnt, 32'd2);

        // Century rule: 2000 is leap, 2100 is not
        cur_date = 32'h29022000;
        repeat (4) press(2);
        check("c2000_ld_value", last_date_ld, 32'h29022000);
        cur_date = 32'h29022099;
        repeat (3) press(2);
        press(0);
        check("c2100_year", set_date, 32'h29022100);
        press(2);
        check("c2100_ld_value", last_date_ld, 32'h28022100);
        check("c2100_ld_date_cnt", ld_date_cnt, 32'd3);

        // Day dec wrap in a 30-day month, then abort by flipping sw_mode
        cur_date = 32'h01042023;
        press(2);
        press(1);
        check("day_dec_wrap30", set_date, 32'h30042023);
        sw_mode = 1'b0;
        tick(2);
        check("mode_abort_idle", 32'(edit_active), 32'd0);
        check("mode_abort_no_ld", ld_date_cnt + ld_time_cnt, 32'd5);

        // Timeout abort after 200 idle cycles
        press(2);
        tick(150);
        check("timeout_still_active", 32'(edit_active), 32'd1);
        tick(50);
        check("timeout_idle", {29'd0, edit_active, edit_field}, 32'd0);
        check("timeout_no_ld", ld_date_cnt + ld_time_cnt, 32'd5);

        // Invalid captured hour, inc+dec cancel, reset mid-edit
        cur_time = 24'h3A1200;
        press(2);
        press(0);
        check("bad_hour_inc_min", 32'(set_time), 32'h001200);
        press(1);
        check("hour_dec_wrap23", 32'(set_time), 32'h231200);
        press(3);
        check("inc_dec_cancel", 32'(set_time), 32'h231200);
        rst = 1'b1;
        tick(1);
        check("midedit_rst_time", 32'(set_time), 32'h0);
        check("midedit_rst_edit", {29'd0, edit_active, edit_field}, 32'd0);
        rst = 1'b0;
        tick(3);
        check("midedit_rst_no_ld", ld_date_cnt + ld_time_cnt, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
